// File: rtl/tb_vp_ctrl.sv
// Virtual-peripheral controller for the core testbench.
// Decodes data-bus accesses to four testbench addresses (print port, cycle
// timer, test status, exit code) and raises the end-of-simulation flags only
// once every character written before them has drained from the print FIFO.
module tb_vp_ctrl #(
    parameter logic [31:0] PRINT_ADDR  = 32'h1000_0000,
    parameter logic [31:0] TIMER_ADDR  = 32'h1500_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
    parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        hit_o,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] PASS_CODE  = 32'h075B_CD15;
    localparam logic [31:0] FAIL_CODE  = 32'h0000_0001;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE_COUNT  = (PW + 1)'(1);

    // Address decode: byte offset within the word is ignored.
    logic [31:0] addr_word;
    logic        sel_print, sel_timer, sel_status, sel_exit;

    assign addr_word  = addr_i & WORD_MASK;
    assign sel_print  = (addr_word == (PRINT_ADDR  & WORD_MASK));
    assign sel_timer  = (addr_word == (TIMER_ADDR  & WORD_MASK));
    assign sel_status = (addr_word == (STATUS_ADDR & WORD_MASK));
    assign sel_exit   = (addr_word == (EXIT_ADDR   & WORD_MASK));
    assign hit_o      = sel_print | sel_timer | sel_status | sel_exit;

    // FIFO bookkeeping
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty;
    logic          wr_gnt, push, pop;
    logic [7:0]    push_byte;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // A full FIFO is the only source of back-pressure, and only for print writes.
    assign gnt_o  = req_i & hit_o & ~(sel_print & we_i & fifo_full);
    assign wr_gnt = gnt_o & we_i;
    assign push   = wr_gnt & sel_print & (be_i != 4'b0000);
    assign pop    = char_valid_o & char_ready_i;

    assign char_valid_o = ~fifo_empty;
    assign char_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    // Pick the byte lane named by the lowest set byte enable.
    always_comb begin
        // NOTE: default first so every path assigns push_byte and no latch is inferred.
        push_byte = wdata_i[7:0];
        if (be_i[0])      push_byte = wdata_i[7:0];
        else if (be_i[1]) push_byte = wdata_i[15:8];
        else if (be_i[2]) push_byte = wdata_i[23:16];
        else if (be_i[3]) push_byte = wdata_i[31:24];
    end

    // FIFO storage: written on push only.
    always_ff @(posedge core_clk) begin
        // NOTE: the storage array has no reset; count/pointers define validity and
        // char_data_o is gated to 0 while the FIFO is empty.
        if (push) fifo_mem[wr_ptr] <= push_byte;
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // in this block samples pre-edge values.
        if (!core_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // Free-running cycle timer, cleared by any granted write to it.
    logic [31:0] timer_q, timer_next;

    assign timer_next = timer_q + 32'd1;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n)              timer_q <= '0;
        else if (wr_gnt && sel_timer) timer_q <= '0;
        else                          timer_q <= timer_next;
    end

    // Status and exit registers: the first accepted write wins.
    logic        pass_pend, fail_pend, exit_pend;
    logic [31:0] exit_value;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            pass_pend  <= 1'b0;
            fail_pend  <= 1'b0;
            exit_pend  <= 1'b0;
            exit_value <= '0;
        end else begin
            if (wr_gnt && sel_status && !pass_pend && !fail_pend) begin
                if (wdata_i == PASS_CODE)      pass_pend <= 1'b1;
                else if (wdata_i == FAIL_CODE) fail_pend <= 1'b1;
            end
            if (wr_gnt && sel_exit && !exit_pend) begin
                exit_pend  <= 1'b1;
                exit_value <= wdata_i;
            end
        end
    end

    // Flags wait for the print FIFO to drain so output ordering is preserved.
    assign tests_passed_o = pass_pend & fifo_empty;
    assign tests_failed_o = fail_pend & fifo_empty;
    assign exit_valid_o   = exit_pend & fifo_empty;
    assign exit_value_o   = exit_value;

    // Read mux; a timer read reports the value the timer takes at the grant edge.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (sel_timer)       rd_mux = timer_next;
        else if (sel_status) rd_mux = {30'b0, fail_pend, pass_pend};
        else if (sel_exit)   rd_mux = exit_value;
    end

    // One-cycle response for every granted access; rdata is 0 unless a read returns.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o;
            rdata_o  <= (gnt_o && !we_i) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_tb_vp_ctrl.sv
// Self-checking bench for tb_vp_ctrl: bus responses and printed characters are
// predicted into scoreboards at grant time and compared by monitors when the
// DUT produces them; flag behaviour is checked inline by each scenario task.
module tb_tb_vp_ctrl;

    localparam logic [31:0] PRINT_ADDR  = 32'h1000_0000;
    localparam logic [31:0] TIMER_ADDR  = 32'h1500_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h2000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
    localparam logic [31:0] PASS_CODE   = 32'h075B_CD15;

    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, char_ready = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        hit, gnt, rvalid, char_valid;
    logic        tests_passed, tests_failed, exit_valid;
    logic [31:0] rdata, exit_value;
    logic [7:0]  char_data;

    logic [31:0] rd_q[$];
    logic [7:0]  char_q[$];
    int          tests_run = 0;
    int          tests_failed_cnt = 0;

    tb_vp_ctrl #(.FIFO_DEPTH(8)) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .hit_o(hit), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .char_valid_o(char_valid), .char_data_o(char_data), .char_ready_i(char_ready),
        .tests_passed_o(tests_passed), .tests_failed_o(tests_failed),
        .exit_valid_o(exit_valid), .exit_value_o(exit_value)
    );

    initial forever #5 core_clk = ~core_clk;

    function automatic logic [7:0] lane_byte(input logic [3:0] b, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (b[i]) return d[8*i +: 8];
        return 8'h00;
    endfunction

    // Response monitor: checks rvalid/rdata against the response scoreboard.
    always @(negedge core_clk) begin
        logic [31:0] exp_r;
        #2;
        if (rvalid) begin
            tests_run++;
            if (rd_q.size() == 0) begin
                tests_failed_cnt++;
                $display("FAIL rvalid_unexpected: rvalid=1 with no granted request, rdata=%h", rdata);
            end else begin
                exp_r = rd_q.pop_front();
                if (rdata !== exp_r) begin
                    tests_failed_cnt++;
                    $display("FAIL rdata: got %h expected %h", rdata, exp_r);
                end
            end
        end else if (rdata !== 32'h0) begin
            tests_run++;
            tests_failed_cnt++;
            $display("FAIL rdata_idle: got %h expected 0 while rvalid=0", rdata);
        end
    end

    // Character monitor: every accepted head byte must match the next expected byte.
    always @(negedge core_clk) begin
        logic [7:0] exp_c;
        #2;
        if (char_valid && char_ready) begin
            tests_run++;
            if (char_q.size() == 0) begin
                tests_failed_cnt++;
                $display("FAIL char_unexpected: got %h with no byte expected", char_data);
            end else begin
                exp_c = char_q.pop_front();
                if (char_data !== exp_c) begin
                    tests_failed_cnt++;
                    $display("FAIL char_order: got %h expected %h", char_data, exp_c);
                end
            end
        end
    end

    task automatic expect_bit(input string name, input logic got, input logic exp_v);
        tests_run++;
        if (got !== exp_v) begin
            tests_failed_cnt++;
            $display("FAIL %s: got %b expected %b", name, got, exp_v);
        end
    endtask

    // One bus access, bounded wait for grant; predicted results go to the scoreboards.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] exp_rdata);
        bit granted = 1'b0;
        @(negedge core_clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        for (int i = 0; i < 50 && !granted; i++) begin
            #1;
            granted = gnt;
            @(posedge core_clk);
            if (!granted) @(negedge core_clk);
        end
        tests_run++;
        if (granted) begin
            rd_q.push_back(w ? 32'h0 : exp_rdata);
            if (w && a == PRINT_ADDR && b != 4'b0000) char_q.push_back(lane_byte(b, d));
        end else begin
            tests_failed_cnt++;
            $display("FAIL grant_timeout: addr %h got gnt=0 expected grant within 50 cycles", a);
            req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge core_clk);
            req = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge core_clk);
        core_rst_n = 1'b0;
        req = 1'b0;
        rd_q.delete();
        char_q.delete();
        repeat (2) @(negedge core_clk);
        core_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        expect_bit("reset_rvalid", rvalid, 1'b0);
        expect_bit("reset_char_valid", char_valid, 1'b0);
        expect_bit("reset_passed", tests_passed, 1'b0);
        expect_bit("reset_failed", tests_failed, 1'b0);
        expect_bit("reset_exit_valid", exit_valid, 1'b0);
        tests_run++;
        if ({rdata, exit_value, char_data} !== '0) begin
            tests_failed_cnt++;
            $display("FAIL reset_data: rdata=%h exit_value=%h char=%h expected all 0", rdata, exit_value, char_data);
        end
        apply_reset();
        do_req(1'b0, TIMER_ADDR, 4'hF, 32'h0, 32'd2);
        idle(1);
    endtask

    task automatic test_hit();
        @(negedge core_clk);
        addr = STATUS_ADDR + 32'd3; req = 1'b0; #1;
        expect_bit("hit_masked", hit, 1'b1);
        addr = 32'h2000_0008; #1;
        expect_bit("hit_miss", hit, 1'b0);
        addr = PRINT_ADDR + 32'd1; #1;
        expect_bit("hit_print", hit, 1'b1);
        addr = 32'h9000_0000; req = 1'b1; we = 1'b1; #1;
        expect_bit("gnt_miss", gnt, 1'b0);
        @(negedge core_clk);
        req = 1'b0; #1;
        expect_bit("rvalid_miss", rvalid, 1'b0);
    endtask

    task automatic test_simple_pass();
        apply_reset();
        do_req(1'b1, STATUS_ADDR, 4'hF, PASS_CODE, 32'h0);
        @(negedge core_clk); req = 1'b0; #1;
        expect_bit("pass_rise", tests_passed, 1'b1);
        expect_bit("pass_no_fail", tests_failed, 1'b0);
        idle(5); #1;
        expect_bit("pass_sticky", tests_passed, 1'b1);
        do_req(1'b0, STATUS_ADDR, 4'hF, 32'h0, 32'h1);
        idle(2);
    endtask

    task automatic test_print_ordering();
        apply_reset();
        char_ready = 1'b0;
        do_req(1'b1, PRINT_ADDR, 4'b0001, 32'h0000_004F, 32'h0);
        do_req(1'b1, PRINT_ADDR, 4'b0001, 32'h0000_004B, 32'h0);
        do_req(1'b1, PRINT_ADDR, 4'b0001, 32'h0000_000A, 32'h0);
        do_req(1'b1, EXIT_ADDR, 4'hF, 32'h0, 32'h0);
        repeat (10) begin
            @(negedge core_clk); req = 1'b0; #1;
            expect_bit("order_exit_held", exit_valid, 1'b0);
        end
        @(negedge core_clk);
        char_ready = 1'b1; #1;
        expect_bit("order_before_pop1", exit_valid, 1'b0);
        repeat (2) begin
            @(negedge core_clk); #1;
            expect_bit("order_mid_drain", exit_valid, 1'b0);
        end
        @(negedge core_clk); #1;
        expect_bit("order_exit_rise", exit_valid, 1'b1);
        tests_run++;
        if (exit_value !== 32'h0) begin
            tests_failed_cnt++;
            $display("FAIL order_exit_value: got %h expected 0", exit_value);
        end
        idle(2);
    endtask

    task automatic test_fifo_full_wrap();
        apply_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            do_req(1'b1, PRINT_ADDR, 4'b0001, 32'h30 + i, 32'h0);
        @(negedge core_clk);
        req = 1'b1; we = 1'b1; addr = PRINT_ADDR; be = 4'b0001; wdata = 32'h38;
        repeat (3) begin
            #1;
            expect_bit("full_gnt_held", gnt, 1'b0);
            @(negedge core_clk);
        end
        char_ready = 1'b1; #1;
        expect_bit("full_gnt_pop_cycle", gnt, 1'b0);
        @(negedge core_clk); #1;
        expect_bit("full_gnt_after_pop", gnt, 1'b1);
        @(posedge core_clk);
        rd_q.push_back(32'h0);
        char_q.push_back(8'h38);
        idle(12); #1;
        expect_bit("full_drained", char_valid, 1'b0);
        tests_run++;
        if (char_q.size() != 0) begin
            tests_failed_cnt++;
            $display("FAIL full_bytes_out: %0d bytes still expected, required 0", char_q.size());
        end
    endtask

    task automatic test_print_lanes();
        char_ready = 1'b1;
        do_req(1'b1, PRINT_ADDR, 4'b0001, 32'h4443_4241, 32'h0);
        do_req(1'b1, PRINT_ADDR, 4'b0100, 32'h4443_4241, 32'h0);
        do_req(1'b1, PRINT_ADDR, 4'b1100, 32'h5A5B_5C5D, 32'h0);
        do_req(1'b1, PRINT_ADDR, 4'b1000, 32'h5A5B_5C5D, 32'h0);
        do_req(1'b1, PRINT_ADDR, 4'b0000, 32'h7777_7777, 32'h0);
        do_req(1'b0, PRINT_ADDR, 4'hF, 32'h0, 32'h0);
        idle(5); #1;
        expect_bit("lanes_drained", char_valid, 1'b0);
        tests_run++;
        if (char_q.size() != 0) begin
            tests_failed_cnt++;
            $display("FAIL lanes_bytes_out: %0d bytes still expected, required 0", char_q.size());
        end
    endtask

    task automatic test_timer();
        do_req(1'b1, TIMER_ADDR, 4'hF, 32'h0, 32'h0);
        idle(1);
        do_req(1'b0, TIMER_ADDR, 4'hF, 32'h0, 32'd2);
        idle(4);
        do_req(1'b0, TIMER_ADDR, 4'hF, 32'h0, 32'd7);
        do_req(1'b1, TIMER_ADDR, 4'hF, 32'h0, 32'h0);
        idle(2);
        do_req(1'b0, TIMER_ADDR, 4'hF, 32'h0, 32'd3);
        idle(1);
        force dut.timer_q = 32'hFFFF_FFFF;
        do_req(1'b0, TIMER_ADDR, 4'hF, 32'h0, 32'h0);
        release dut.timer_q;
        idle(2);
    endtask

    task automatic test_first_wins();
        apply_reset();
        do_req(1'b1, STATUS_ADDR, 4'hF, 32'h5, 32'h0);
        idle(1); #1;
        expect_bit("ignore_pass", tests_passed, 1'b0);
        expect_bit("ignore_fail", tests_failed, 1'b0);
        do_req(1'b1, STATUS_ADDR, 4'hF, 32'h1, 32'h0);
        idle(1); #1;
        expect_bit("fail_rise", tests_failed, 1'b1);
        do_req(1'b1, STATUS_ADDR, 4'hF, PASS_CODE, 32'h0);
        idle(1); #1;
        expect_bit("first_wins_pass", tests_passed, 1'b0);
        expect_bit("first_wins_fail", tests_failed, 1'b1);
        do_req(1'b0, STATUS_ADDR, 4'hF, 32'h0, 32'h2);
        do_req(1'b1, EXIT_ADDR, 4'hF, 32'd7, 32'h0);
        idle(1); #1;
        expect_bit("exit_rise", exit_valid, 1'b1);
        do_req(1'b1, EXIT_ADDR, 4'hF, 32'd9, 32'h0);
        idle(1); #1;
        tests_run++;
        if (exit_value !== 32'd7) begin
            tests_failed_cnt++;
            $display("FAIL exit_first_wins: got %0d expected 7", exit_value);
        end
        do_req(1'b0, EXIT_ADDR, 4'hF, 32'h0, 32'd7);
        idle(2);
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            do_req(1'b1, PRINT_ADDR, 4'b0001, 32'h61 + i, 32'h0);
        do_req(1'b1, EXIT_ADDR, 4'hF, 32'd5, 32'h0);
        idle(2); #1;
        expect_bit("drain_exit_held", exit_valid, 1'b0);
        @(negedge core_clk);
        core_rst_n = 1'b0; #1;
        tests_run++;
        if ({rvalid, char_valid, tests_passed, tests_failed, exit_valid} !== 5'b0 ||
            {rdata, exit_value, char_data} !== '0) begin
            tests_failed_cnt++;
            $display("FAIL mid_reset_outputs: char_valid=%b exit_valid=%b exit_value=%h expected all 0",
                     char_valid, exit_valid, exit_value);
        end
        rd_q.delete();
        char_q.delete();
        @(negedge core_clk);
        core_rst_n = 1'b1;
        char_ready = 1'b1;
        idle(5); #1;
        expect_bit("post_reset_no_exit", exit_valid, 1'b0);
        expect_bit("post_reset_no_char", char_valid, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_simple_pass();
        test_print_ordering();
        test_fifo_full_wrap();
        test_print_lanes();
        test_timer();
        test_first_wins();
        test_reset_mid_drain();
        idle(3);
        tests_run++;
        if (rd_q.size() != 0) begin
            tests_failed_cnt++;
            $display("FAIL responses_missing: %0d responses outstanding, required 0", rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed_cnt);
        $finish;
    end

endmodule
